// File: rtl/debounce_pkg.sv
// Shared definitions for the debounced-input path: state encoding and level decode.
// Bit 1 of the state encoding is the debounced level itself.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t STABLE_LO = 2'b00;
    localparam state_t WAIT_HI   = 2'b01;
    localparam state_t STABLE_HI = 2'b11;
    localparam state_t WAIT_LO   = 2'b10;

    function automatic logic level_of(input state_t st);
        return st[1];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reusable by any raw input path.
module sync_2ff (
    input  logic Clock,
    input  logic Resetn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Free-running capture chain, cleared by the asynchronous reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces a raw input into a clean level w plus one-cycle rise/fall pulses.
// The FSM and counter only advance on tick-qualified edges; the synchroniser always runs.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic tick,
    input  logic d_in,
    output logic w,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_w;
    logic             r_rise;
    logic             r_fall;
    logic             w_w_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    sync_2ff u_sync (
        .Clock  (Clock),
        .Resetn (Resetn),
        .d      (d_in),
        .q      (w_s)
    );

    // State, counter and output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= STABLE_LO;
            r_cnt   <= CNT_ZERO;
            r_w     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_w     <= w_w_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next-state and counter: a level change is accepted only after an unbroken run of samples.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (tick) begin
            case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        w_state_nxt = WAIT_HI;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = STABLE_LO;
                    end
                end
                WAIT_HI: begin
                    if (!w_s) begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        w_state_nxt = WAIT_LO;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = STABLE_HI;
                    end
                end
                WAIT_LO: begin
                    if (w_s) begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Outputs decoded from the transition so they update on the same edge as the state.
    always_comb begin
        w_w_nxt    = level_of(w_state_nxt);
        w_rise_nxt = (r_state == WAIT_HI) && (w_state_nxt == STABLE_HI);
        w_fall_nxt = (r_state == WAIT_LO) && (w_state_nxt == STABLE_LO);
    end

    assign w    = r_w;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
